// File: rtl/tpum_xbox_row_loader.sv
// -----------------------------------------------------------------------------
// tpum_xbox_row_loader
//
// Moves one XBOX/PUM row per request between the XBOX memory and the TPUM
// register vectors.
//   read : fetch a ROW_W-bit row, then stream it as 32 indexed WORD_W-bit words
//          towards R1 (req_target = 0) or R2 (req_target = 1).
//   write: store the latched request row (packed RA vector) to XBOX.
// Each transaction ends with a one-cycle done pulse; err qualifies done.
//
// Optional feature (macro TPUM_XBOX_ADDR_CHECK_EN): requests whose address is
// >= XBOX_DEPTH are rejected from IDLE straight to DONE with err = 1, and no
// XBOX strobe or word is produced. Without the macro err is tied to 0 and all
// addresses are issued unchanged.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake
//   req_write, req_target      1 = row write / read destination (0 = R1, 1 = R2)
//   req_addr, req_wdata        row address, row data for writes
//   word_valid/word_ready      unpacked word handshake towards the register file
//   word_target, word_idx      latched destination, word index 0..31
//   word_data                  word payload
//   done, err                  completion pulse, rejection qualifier
//   xbox_rd, xbox_wr           XBOX read / write strobes (never both high)
//   xbox_addr, xbox_wdata      latched address / latched row
//   xbox_rdata                 XBOX read data, valid RD_LATENCY cycles after xbox_rd
//
// Handshake rule (both interfaces): a transfer happens on a rising edge where
// valid and ready are both 1. Once valid is raised the producer holds its
// payload stable until that edge. A consumer may change ready at any time.
//
// Every output decodes from the state register or from other registers, so
// there is no combinational path from any input to any output.
// -----------------------------------------------------------------------------
module tpum_xbox_row_loader #(
  parameter int ADDR_W     = 14,
  parameter int ROW_W      = 1024,
  parameter int WORD_W     = 32,
  parameter int RD_LATENCY = 2,
  parameter int XBOX_DEPTH = 12288
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_target,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ROW_W-1:0]  req_wdata,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              word_target,
  output logic [4:0]        word_idx,
  output logic [WORD_W-1:0] word_data,
  output logic              done,
  output logic              err,
  output logic              xbox_rd,
  output logic              xbox_wr,
  output logic [ADDR_W-1:0] xbox_addr,
  output logic [ROW_W-1:0]  xbox_wdata,
  input  logic [ROW_W-1:0]  xbox_rdata
);

  // Elaboration-time parameter sanity checks.
  if (ROW_W != 32 * WORD_W) begin : g_bad_row_w
    $error("tpum_xbox_row_loader: ROW_W must equal 32*WORD_W");
  end
  if (RD_LATENCY < 1) begin : g_bad_rd_latency
    $error("tpum_xbox_row_loader: RD_LATENCY must be >= 1");
  end
  if (XBOX_DEPTH < 1 || XBOX_DEPTH > (1 << ADDR_W)) begin : g_bad_depth
    $error("tpum_xbox_row_loader: XBOX_DEPTH must be in 1..2**ADDR_W");
  end

  localparam int LAT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam int SEL_W = $clog2(ROW_W);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_WAIT  = 3'd2,
    UNPACK   = 3'd3,
    WR_ISSUE = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [LAT_W-1:0]   lat_cnt_q;
  logic [4:0]         idx_q;
  logic               target_q;
  logic [ADDR_W-1:0]  addr_q;
  // One row register serves both directions: it holds the request row for a
  // write and is overwritten with the fetched row for a read.
  logic [ROW_W-1:0]   row_q;
  logic               lat_done;
  logic               accept;
  logic               last_word;
  logic               addr_bad;
  logic [SEL_W-1:0]   bit_off;

  assign accept    = (state_q == IDLE) && req_valid;
  // The strobe was in cycle t; the count reaches RD_LATENCY-1 in cycle
  // t+RD_LATENCY, which is the cycle xbox_rdata is valid.
  assign lat_done  = (lat_cnt_q == LAT_W'(RD_LATENCY - 1));
  assign last_word = (idx_q == 5'd31) && word_ready;

`ifdef TPUM_XBOX_ADDR_CHECK_EN
  logic err_q;

  assign addr_bad = (32'(req_addr) >= 32'(XBOX_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= addr_bad;
    end
  end

  assign err = (state_q == DONE) && err_q;
`else
  assign addr_bad = 1'b0;
  assign err      = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (addr_bad) begin
            state_d = DONE;
          end else if (req_write) begin
            state_d = WR_ISSUE;
          end else begin
            state_d = RD_ISSUE;
          end
        end
      end
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT: begin
        if (lat_done) begin
          state_d = UNPACK;
        end
      end
      UNPACK: begin
        if (last_word) begin
          state_d = DONE;
        end
      end
      WR_ISSUE: state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_cnt_q <= '0;
      idx_q     <= '0;
      target_q  <= 1'b0;
      addr_q    <= '0;
      row_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            target_q  <= req_target;
            addr_q    <= req_addr;
            row_q     <= req_wdata;
            lat_cnt_q <= '0;
            idx_q     <= '0;
          end
        end
        RD_WAIT: begin
          lat_cnt_q <= lat_cnt_q + LAT_W'(1);
          if (lat_done) begin
            row_q <= xbox_rdata;
          end
        end
        UNPACK: begin
          // The index stops at 31; the final handshake leaves for DONE.
          if (word_ready && (idx_q != 5'd31)) begin
            idx_q <= idx_q + 5'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (registered state / registers only)
  // ---------------------------------------------------------------------------
  assign bit_off = SEL_W'(idx_q) * SEL_W'(WORD_W);

  assign req_ready   = (state_q == IDLE);
  assign xbox_rd     = (state_q == RD_ISSUE);
  assign xbox_wr     = (state_q == WR_ISSUE);
  assign done        = (state_q == DONE);
  assign word_valid  = (state_q == UNPACK);
  // Word fields read 0 outside UNPACK so an idle bus is quiet.
  assign word_target = word_valid ? target_q : 1'b0;
  assign word_idx    = word_valid ? idx_q : 5'd0;
  assign word_data   = word_valid ? row_q[bit_off +: WORD_W] : '0;
  assign xbox_addr   = addr_q;
  assign xbox_wdata  = row_q;

endmodule

// File: tb/tb_tpum_xbox_row_loader.sv
// -----------------------------------------------------------------------------
// tb_tpum_xbox_row_loader
//
// Directed bench for tpum_xbox_row_loader with RD_LATENCY = 2. A small XBOX
// model returns a row whose word k equals mem_base + k, only in the cycle that
// is RD_LATENCY cycles after the read strobe (all ones otherwise). Expected
// words sit in exp_q and are popped as the loader hands them over.
// -----------------------------------------------------------------------------
module tb_tpum_xbox_row_loader;

  localparam int ADDR_W = 14;
  localparam int ROW_W  = 1024;
  localparam int WORD_W = 32;
  localparam int RD_LAT = 2;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic              req_target;
  logic [ADDR_W-1:0] req_addr;
  logic [ROW_W-1:0]  req_wdata;
  logic              word_valid;
  logic              word_ready;
  logic              word_target;
  logic [4:0]        word_idx;
  logic [WORD_W-1:0] word_data;
  logic              done;
  logic              err;
  logic              xbox_rd;
  logic              xbox_wr;
  logic [ADDR_W-1:0] xbox_addr;
  logic [ROW_W-1:0]  xbox_wdata;
  logic [ROW_W-1:0]  xbox_rdata;

  int checks = 0;
  int errors = 0;
  logic [36:0] exp_q[$];     // {idx[4:0], data[31:0]}
  logic [31:0] mem_base;
  logic [RD_LAT-1:0] rd_pipe;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  tpum_xbox_row_loader #(
    .ADDR_W(ADDR_W), .ROW_W(ROW_W), .WORD_W(WORD_W),
    .RD_LATENCY(RD_LAT), .XBOX_DEPTH(12288)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_target(req_target), .req_addr(req_addr), .req_wdata(req_wdata),
    .word_valid(word_valid), .word_ready(word_ready), .word_target(word_target),
    .word_idx(word_idx), .word_data(word_data),
    .done(done), .err(err),
    .xbox_rd(xbox_rd), .xbox_wr(xbox_wr), .xbox_addr(xbox_addr),
    .xbox_wdata(xbox_wdata), .xbox_rdata(xbox_rdata)
  );

  function automatic logic [ROW_W-1:0] make_row(input logic [31:0] base);
    logic [ROW_W-1:0] r;
    r = '0;
    for (int k = 0; k < 32; k++) r[k*32 +: 32] = base + 32'(k);
    return r;
  endfunction

  // XBOX model: data is valid only in cycle t+RD_LAT after the strobe in cycle t.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_pipe <= '0;
    else        rd_pipe <= {rd_pipe[RD_LAT-2:0], xbox_rd};
  end
  assign xbox_rdata = rd_pipe[RD_LAT-1] ? make_row(mem_base) : {ROW_W{1'b1}};

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues a read in the current cycle (cycle 0) and follows it to completion.
  // stall_at/stall_len: hold word_ready low for stall_len cycles at that index.
  // hold_valid: keep req_valid high throughout. rst_at: assert reset at that index.
  task automatic run_read(input logic [ADDR_W-1:0] addr, input logic tgt,
                          input logic [31:0] base, input int stall_at,
                          input int stall_len, input bit hold_valid, input int rst_at);
    int cyc;
    int first_cyc;
    int last_acc;
    int done_cyc;
    int rd_cnt;
    int busy_ready;
    int stall_left;
    first_cyc  = -1;
    last_acc   = -1;
    done_cyc   = -1;
    rd_cnt     = 0;
    busy_ready = 0;
    stall_left = stall_len;
    mem_base   = base;
    exp_q.delete();
    for (int k = 0; k < 32; k++) exp_q.push_back({5'(k), base + 32'(k)});
    check("rd_idle_ready", {63'd0, req_ready}, 64'd1);
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_target = tgt;
    req_addr   = addr;
    req_wdata  = '0;
    word_ready = 1'b1;
    cyc = 0;
    while (done_cyc < 0 && cyc < 300) begin
      tick();
      cyc++;
      if (!hold_valid) req_valid = 1'b0;
      if (xbox_rd) begin
        rd_cnt++;
        check("rd_addr", 64'(xbox_addr), 64'(addr));
        check("rd_cycle", 64'(cyc), 64'd1);
      end
      if (xbox_wr) check("rd_no_wr", 64'd1, 64'd0);
      if (req_ready) busy_ready++;
      if (done) begin
        done_cyc = cyc;
        check("rd_err", {63'd0, err}, 64'd0);
      end
      word_ready = 1'b1;
      if (word_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (rst_at >= 0 && int'(word_idx) == rst_at) begin
          rst_n = 1'b0;
          #1;
          check("rst_word_valid", {63'd0, word_valid}, 64'd0);
          check("rst_req_ready", {63'd0, req_ready}, 64'd1);
          check("rst_strobes", {62'd0, xbox_rd, xbox_wr}, 64'd0);
          check("rst_done_err", {62'd0, done, err}, 64'd0);
          check("rst_word_fields", {26'd0, word_target, word_idx, word_data}, 64'd0);
          check("rst_xbox_addr", 64'(xbox_addr), 64'd0);
          check("rst_xbox_wdata", {63'd0, xbox_wdata == '0}, 64'd1);
          #2;
          rst_n     = 1'b1;
          req_valid = 1'b0;
          exp_q.delete();
          tick();
          return;
        end
        if (exp_q.size() == 0) begin
          check("word_extra", 64'd1, 64'd0);
        end else begin
          check("word_idx", 64'(word_idx), 64'(exp_q[0][36:32]));
          check("word_data", 64'(word_data), 64'(exp_q[0][31:0]));
          check("word_target", {63'd0, word_target}, {63'd0, tgt});
          if (stall_left > 0 && int'(word_idx) == stall_at) begin
            word_ready = 1'b0;
            stall_left--;
          end else begin
            void'(exp_q.pop_front());
            last_acc = cyc;
          end
        end
      end
    end
    if (done_cyc < 0) check("rd_done_timeout", 64'd0, 64'd1);
    check("rd_strobe_count", 64'(rd_cnt), 64'd1);
    check("rd_first_word_cyc", 64'(first_cyc), 64'(2 + RD_LAT));
    check("rd_done_after_last", 64'(done_cyc), 64'(last_acc + 1));
    check("rd_done_cyc", 64'(done_cyc), 64'(34 + RD_LAT + stall_len));
    check("rd_words_left", 64'(exp_q.size()), 64'd0);
    check("rd_busy_ready", 64'(busy_ready), 64'd0);
    tick();
    check("rd_ready_after", {63'd0, req_ready}, 64'd1);
    check("rd_done_one_cycle", {63'd0, done}, 64'd0);
  endtask

  task automatic run_write(input logic [ADDR_W-1:0] addr, input logic [ROW_W-1:0] row);
    check("wr_idle_ready", {63'd0, req_ready}, 64'd1);
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_target = 1'b0;
    req_addr   = addr;
    req_wdata  = row;
    tick();
    req_valid = 1'b0;
    req_write = 1'b0;
    req_wdata = '0;
    check("wr_strobe", {62'd0, xbox_wr, xbox_rd}, 64'd2);
    check("wr_addr", 64'(xbox_addr), 64'(addr));
    check("wr_wdata", {63'd0, xbox_wdata == row}, 64'd1);
    check("wr_busy", {61'd0, req_ready, done, word_valid}, 64'd0);
    tick();
    check("wr_done", {61'd0, done, err, xbox_wr}, 64'd4);
    check("wr_no_word", {63'd0, word_valid}, 64'd0);
    tick();
    check("wr_ready_after", {62'd0, req_ready, done}, 64'd2);
  endtask

`ifdef TPUM_XBOX_ADDR_CHECK_EN
  task automatic run_oob(input logic [ADDR_W-1:0] addr);
    check("oob_idle_ready", {63'd0, req_ready}, 64'd1);
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_target = 1'b1;
    req_addr   = addr;
    tick();
    req_valid = 1'b0;
    check("oob_done_err", {62'd0, done, err}, 64'd3);
    check("oob_no_strobe", {62'd0, xbox_rd, xbox_wr}, 64'd0);
    check("oob_no_word", {63'd0, word_valid}, 64'd0);
    tick();
    check("oob_after", {61'd0, req_ready, done, err}, 64'd4);
  endtask
`endif

  // ---------------------------------------------------------------------------
  // Stimulus and report
  // ---------------------------------------------------------------------------
  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_target = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    word_ready = 1'b1;
    mem_base   = '0;
    #12;
    check("reset_req_ready", {63'd0, req_ready}, 64'd1);
    check("reset_outputs", {58'd0, word_valid, done, err, xbox_rd, xbox_wr, word_target}, 64'd0);
    check("reset_word", {27'd0, word_idx, word_data}, 64'd0);
    check("reset_xbox_addr", 64'(xbox_addr), 64'd0);
    #3 rst_n = 1'b1;
    tick();

    run_read(14'h0010, 1'b0, 32'hA500_0000, -1, 0, 1'b0, -1);
    run_write(14'h1FFF, {128{8'h5A}});
    run_read(14'h0123, 1'b1, 32'h3C00_0000, 7, 3, 1'b0, -1);
    // req_valid held through a whole read; the second read starts right after DONE.
    run_read(14'h0200, 1'b0, 32'h1111_0000, -1, 0, 1'b1, -1);
    run_read(14'h0201, 1'b1, 32'h2222_0000, -1, 0, 1'b0, -1);
    // Reset during UNPACK at index 12, then a fresh read with new data.
    run_read(14'h0300, 1'b1, 32'h7770_0000, -1, 0, 1'b0, 12);
    run_read(14'h0300, 1'b1, 32'h8880_0000, -1, 0, 1'b0, -1);
    run_write(14'h0000, make_row(32'hC0DE_0000));
`ifdef TPUM_XBOX_ADDR_CHECK_EN
    run_oob(14'd12288);
    run_oob(14'h3FFF);
    run_read(14'd12287, 1'b0, 32'h4400_0000, -1, 0, 1'b0, -1);
`else
    run_read(14'd12288, 1'b0, 32'h4400_0000, -1, 0, 1'b0, -1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tpum_xbox_row_loader.md
Name: tpum_xbox_row_loader

Overview:
- Sits between the TPUM control FSM and the XBOX/PUM memory.
- Executes one row transaction per request: either reads a 1024-bit XBOX row and streams it as 32 indexed 32-bit words into the R1/R2 register vectors, or writes a 1024-bit row (the packed RA vector) back to XBOX.
- Reports completion with a one-cycle done pulse.
- The FSM uses it for its INITR1/INITR2 loads and for result write-back.

Parameters:
- ADDR_W, 14, XBOX row address width.
- ROW_W, 1024, XBOX row width; must equal 32*WORD_W.
- WORD_W, 32, register-file word width.
- RD_LATENCY, 2, XBOX read latency in cycles (>=1).
- XBOX_DEPTH, 12288, number of valid rows; used only by the optional feature.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  loader can accept a request
- req_write  in  1  1 = row write, 0 = row read
- req_target  in  1  read destination: 0 = R1, 1 = R2
- req_addr  in  ADDR_W  XBOX row address
- req_wdata  in  ROW_W  row data for writes
- word_valid  out  1  unpacked word present
- word_ready  in  1  register file accepts word
- word_target  out  1  latched req_target
- word_idx  out  5  word index 0..31
- word_data  out  WORD_W  word payload
- done  out  1  one-cycle completion pulse
- err  out  1  qualifies done; 1 = request rejected
- xbox_rd  out  1  XBOX read strobe
- xbox_wr  out  1  XBOX write strobe
- xbox_addr  out  ADDR_W  XBOX address
- xbox_wdata  out  ROW_W  XBOX write data
- xbox_rdata  in  ROW_W  XBOX read data

Behaviour:
- Reset and clock: reset rst_n, asynchronous, active-low; clock clk.
- Reset values: state = IDLE; all outputs 0 except req_ready = 1. All latched fields and the row buffer are cleared.
- Reset mid-operation: aborts immediately; any in-flight XBOX read data is discarded.
- States: IDLE, RD_ISSUE, RD_WAIT, UNPACK, WR_ISSUE, DONE.
- Output timing: all outputs decode from registered state or registers only; there is no combinational path from any input to any output.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch req_write, req_target, req_addr and req_wdata.
  - Go to WR_ISSUE if req_write = 1, else to RD_ISSUE.
- Requests while busy: req_ready = 0 in every state other than IDLE; req_valid is ignored.
- RD_ISSUE: xbox_rd = 1 for exactly one cycle (cycle t); go to RD_WAIT.
- RD_WAIT:
  - Counts RD_LATENCY cycles.
  - xbox_rdata is valid in cycle t+RD_LATENCY and is captured into the row buffer on that cycle's closing edge; then go to UNPACK.
- UNPACK:
  - word_valid = 1, word_idx = k, word_data = row[32k+31:32k], word_target = latched target.
  - k starts at 0 and advances only on word_valid & word_ready.
  - While word_ready = 0, all word outputs hold stable.
  - The handshake at k = 31 goes to DONE; k does not wrap.
- WR_ISSUE: xbox_wr = 1 for one cycle with xbox_wdata = latched row; go to DONE.
- DONE: done = 1 for one cycle; go to IDLE. req_ready is 0 during this cycle.
- xbox_addr and xbox_wdata always drive the latched values; they are valid whenever a strobe is high.
- xbox_rd and xbox_wr are never high together.
- Read latency with word_ready held 1 (accept edge at end of cycle 0):
  - xbox_rd in cycle 1.
  - Words in cycles 2+RD_LATENCY through 33+RD_LATENCY.
  - done in cycle 34+RD_LATENCY.
- Write latency: xbox_wr in cycle 1, done in cycle 2.
- Back-to-back: the next request is accepted in the cycle after DONE at the earliest.

Optional Feature:
- Macro: TPUM_XBOX_ADDR_CHECK_EN.
- Defined: in IDLE, a request with req_addr >= XBOX_DEPTH goes directly to DONE with done = 1 and err = 1. No xbox_rd/xbox_wr is issued and no words are emitted.
- Undefined: no check is performed, err is tied to 0, and every address is issued to XBOX unchanged.

Test Plan:
- Read, addr 0x0010, target R1, RD_LATENCY = 2, word_ready = 1, rdata word k = 0xA5000000+k -> xbox_rd in cycle 1 with addr 0x0010; words idx 0..31 with data 0xA5000000..0xA500001F and target 0 in cycles 4..35; done in cycle 36; err = 0.
- Write, addr 0x1FFF, wdata all 0x5A bytes -> xbox_wr for one cycle in cycle 1 with addr 0x1FFF and wdata all 0x5A; done in cycle 2; word_valid never asserted.
- Read with word_ready deasserted for 3 cycles at idx 7 -> idx 7 and its data held stable for 3 cycles; still 32 distinct words in order; done one cycle after idx 31 accepted.
- req_valid held high through an entire read -> exactly one request accepted; the second is accepted in the cycle after done; req_ready = 0 throughout the busy period.
- rst_n asserted in UNPACK at idx 12 -> all outputs 0 and req_ready = 1 immediately; a fresh read restarts at idx 0 with newly fetched data.
- With TPUM_XBOX_ADDR_CHECK_EN, read addr 12288 -> done = 1 and err = 1 in cycle 1; no xbox strobe; no words emitted.
